// File: rtl/step_sequencer_if.sv
// Direction-byte input stream and arrow-event output stream of the step sequencer.
interface step_sequencer_if;
  logic       in_valid;
  logic [7:0] in_dir;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_dir;
  logic       out_ready;

  modport master (
    output in_valid, in_dir, out_ready,
    input  in_ready, out_valid, out_dir
  );

  modport slave (
    input  in_valid, in_dir, out_ready,
    output in_ready, out_valid, out_dir
  );
endinterface

// File: rtl/step_sequencer.sv
// Buffers chart direction codes in a FIFO and releases one arrow per step period,
// with the period shortened by the difficulty level.
module step_sequencer #(
  parameter int DEPTH      = 16,
  parameter int BASE_TICKS = 64,
  parameter int TICK_STEP  = 4,
  parameter int MIN_TICKS  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  step_sequencer_if.slave          bus,
  input  logic                     lvl_valid,
  input  logic [7:0]               lvl_in,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic signed [16:0] BASE_S  = 17'(BASE_TICKS);
  localparam logic signed [16:0] TSTEP_S = 17'(TICK_STEP);
  localparam logic signed [16:0] MIN_S   = 17'(MIN_TICKS);
  localparam logic [7:0]         END_MARK = 8'hFF;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT, S_DONE} state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [15:0]       tick;
  logic              out_valid_q;
  logic [7:0]        out_dir_q;
  logic [7:0]        head;
  logic              full, empty, push, pop, accept, marker_pop;
  logic signed [16:0] p_raw, p_eff;
  logic [15:0]       tick_load;

  assign head       = mem[rd_ptr];
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign push       = bus.in_valid && !full;
  assign accept     = (state == S_EMIT) && out_valid_q && bus.out_ready;
  assign marker_pop = (state == S_WAIT) && (tick == '0) && !empty && (head == END_MARK);
  assign pop        = accept || marker_pop;

  assign bus.in_ready  = !full;
  assign bus.out_valid = out_valid_q;
  assign bus.out_dir   = out_dir_q;
  assign busy          = (state == S_WAIT) || (state == S_EMIT);
  assign done          = (state == S_DONE);

  // Level cannot change in WAIT/EMIT, so the period derived from it is stable there.
  always_comb begin
    p_raw     = BASE_S - $signed({9'd0, level}) * TSTEP_S;
    p_eff     = (p_raw < MIN_S) ? MIN_S : p_raw;
    tick_load = 16'(p_eff - 17'sd1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_dir;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      level       <= '0;
      tick        <= '0;
      out_valid_q <= 1'b0;
      out_dir_q   <= '0;
      underrun    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase

      case (state)
        S_IDLE, S_DONE: begin
          if (lvl_valid) level <= lvl_in;
          if (start) begin
            if (!empty) begin
              state <= S_WAIT;
              tick  <= tick_load;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_WAIT: begin
          // At zero the counter holds and the head is re-examined every cycle.
          if (tick != '0) begin
            tick <= tick - 16'd1;
          end else if (empty) begin
            underrun <= 1'b1;
          end else if (head == END_MARK) begin
            state <= S_DONE;
          end else begin
            state       <= S_EMIT;
            out_valid_q <= 1'b1;
            out_dir_q   <= head;
          end
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_WAIT;
            tick        <= tick_load;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
